// File: rtl/mlp_seq_ctrl.sv
// Sequencer for a two-layer MLP over a lane-parallel MAC: loads inputs and weight rows,
// issues MAC beats, writes each neuron result back and tracks the output-layer argmax.
module mlp_seq_ctrl #(
  parameter int LANES  = 50,
  parameter int N_IN   = 1000,
  parameter int N_HID  = 100,
  parameter int N_OUT  = 2,
  parameter int DATA_W = 8,
  parameter int AW     = 12,
  localparam int C1    = (N_IN + LANES - 1) / LANES,
  localparam int C2    = (N_HID + LANES - 1) / LANES,
  localparam int C_MAX = (C1 > C2) ? C1 : C2,
  localparam int WAW   = $clog2(C_MAX + 1),
  localparam int CAT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     w_valid,
  output logic                     w_ready,
  output logic                     act_re,
  output logic                     act_we,
  output logic                     act_wsel,
  output logic [AW-1:0]            act_addr,
  output logic                     w_we,
  output logic                     w_re,
  output logic [WAW-1:0]           w_addr,
  output logic                     mac_clr,
  output logic                     mac_en,
  output logic                     mac_bias,
  input  logic                     res_valid,
  input  logic signed [DATA_W-1:0] res_data,
  output logic                     done,
  output logic [CAT_W-1:0]         category
);

  localparam int HID_BASE = C1 * LANES;
  localparam int OUT_BASE = HID_BASE + C2 * LANES;
  localparam int N_MAX    = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int NW       = (N_MAX > 1) ? $clog2(N_MAX) : 1;

  localparam logic [AW-1:0]  LANES_A    = AW'(LANES);
  localparam logic [AW-1:0]  HID_A      = AW'(HID_BASE);
  localparam logic [AW-1:0]  OUT_A      = AW'(OUT_BASE);
  localparam logic [WAW-1:0] C1_W       = WAW'(C1);
  localparam logic [WAW-1:0] C2_W       = WAW'(C2);
  localparam logic [WAW-1:0] C1_LAST    = WAW'(C1 - 1);
  localparam logic [NW-1:0]  N_HID_LAST = NW'(N_HID - 1);
  localparam logic [NW-1:0]  N_OUT_LAST = NW'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IN, S_LOAD_W, S_MAC, S_WAIT, S_WB, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [WAW-1:0]             k_q, k_d;
  logic [WAW-1:0]             j_q, j_d;
  logic [WAW-1:0]             i_q, i_d;
  logic [NW-1:0]              n_q, n_d;
  logic                       layer_q, layer_d;
  logic [CAT_W-1:0]           cat_q, cat_d;
  logic signed [DATA_W-1:0]   best_q, best_d;

  logic                       mac_en_p0, mac_clr_p0, mac_bias_p0;
  logic                       mac_en_p1, mac_clr_p1, mac_bias_p1;

  logic [WAW-1:0]             cl;
  logic [NW-1:0]              n_last;
  logic [AW-1:0]              in_base;

  assign cl      = layer_q ? C2_W : C1_W;
  assign n_last  = layer_q ? N_OUT_LAST : N_HID_LAST;
  assign in_base = layer_q ? HID_A : '0;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    j_d         = j_q;
    i_d         = i_q;
    n_d         = n_q;
    layer_d     = layer_q;
    cat_d       = cat_q;
    best_d      = best_q;
    busy        = 1'b0;
    in_ready    = 1'b0;
    w_ready     = 1'b0;
    act_re      = 1'b0;
    act_we      = 1'b0;
    act_wsel    = 1'b0;
    act_addr    = '0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_addr      = '0;
    done        = 1'b0;
    mac_en_p0   = 1'b0;
    mac_clr_p0  = 1'b0;
    mac_bias_p0 = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_IN;
          k_d     = '0;
        end
      end

      S_LOAD_IN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        act_addr = AW'(k_q) * LANES_A;
        if (in_valid) begin
          act_we = 1'b1;
          if (k_q == C1_LAST) begin
            state_d = S_LOAD_W;
            layer_d = 1'b0;
            n_d     = '0;
            j_d     = '0;
          end else begin
            k_d = k_q + WAW'(1);
          end
        end
      end

      // Row CL of each neuron's weight stream is its bias row
      S_LOAD_W: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        w_addr  = j_q;
        if (w_valid) begin
          w_we = 1'b1;
          if (j_q == cl) begin
            state_d = S_MAC;
            i_d     = '0;
          end else begin
            j_d = j_q + WAW'(1);
          end
        end
      end

      S_MAC: begin
        busy        = 1'b1;
        act_re      = 1'b1;
        w_re        = 1'b1;
        act_addr    = in_base + AW'(i_q) * LANES_A;
        w_addr      = i_q;
        mac_en_p0   = 1'b1;
        mac_clr_p0  = (i_q == '0);
        mac_bias_p0 = (i_q == cl);
        if (i_q == cl) begin
          state_d = S_WAIT;
        end else begin
          i_d = i_q + WAW'(1);
        end
      end

      S_WAIT: begin
        busy = 1'b1;
        if (res_valid) begin
          state_d = S_WB;
        end
      end

      // Strict greater-than keeps the lowest index on ties
      S_WB: begin
        busy     = 1'b1;
        act_we   = 1'b1;
        act_wsel = 1'b1;
        act_addr = (layer_q ? OUT_A : HID_A) + AW'(n_q);
        if (layer_q && ((n_q == '0) || (res_data > best_q))) begin
          best_d = res_data;
          cat_d  = CAT_W'(n_q);
        end
        if (n_q != n_last) begin
          n_d     = n_q + NW'(1);
          j_d     = '0;
          state_d = S_LOAD_W;
        end else if (!layer_q) begin
          layer_d = 1'b1;
          n_d     = '0;
          j_d     = '0;
          state_d = S_LOAD_W;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // p0 -> p1: MAC strobes trail the issuing read by the 1-cycle memory latency
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      j_q         <= '0;
      i_q         <= '0;
      n_q         <= '0;
      layer_q     <= 1'b0;
      cat_q       <= '0;
      mac_en_p1   <= 1'b0;
      mac_clr_p1  <= 1'b0;
      mac_bias_p1 <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      j_q         <= j_d;
      i_q         <= i_d;
      n_q         <= n_d;
      layer_q     <= layer_d;
      cat_q       <= cat_d;
      mac_en_p1   <= mac_en_p0;
      mac_clr_p1  <= mac_clr_p0;
      mac_bias_p1 <= mac_bias_p0;
    end
  end

  always_ff @(posedge clk) begin
    best_q <= best_d;
  end

  assign mac_en   = mac_en_p1;
  assign mac_clr  = mac_clr_p1;
  assign mac_bias = mac_bias_p1;
  assign category = cat_q;

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Directed bench for mlp_seq_ctrl (LANES=4, N_IN=8, N_HID=4, N_OUT=3) with a behavioural
// MAC responder that returns res_valid two cycles after the bias beat.
module tb_mlp_seq_ctrl;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic              act_re, act_we, act_wsel;
  logic [11:0]       act_addr;
  logic              w_we, w_re;
  logic [1:0]        w_addr;
  logic              mac_clr, mac_en, mac_bias;
  logic              res_valid = 1'b0;
  logic signed [7:0] res_data = 8'sd0;
  logic              done;
  logic [1:0]        category;

  mlp_seq_ctrl #(
    .LANES(4), .N_IN(8), .N_HID(4), .N_OUT(3), .DATA_W(8), .AW(12)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .w_valid(w_valid), .w_ready(w_ready),
    .act_re(act_re), .act_we(act_we), .act_wsel(act_wsel), .act_addr(act_addr),
    .w_we(w_we), .w_re(w_re), .w_addr(w_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_bias(mac_bias),
    .res_valid(res_valid), .res_data(res_data),
    .done(done), .category(category)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] all_out;
  assign all_out = {36'd0, busy, in_ready, w_ready, act_re, act_we, act_wsel, act_addr,
                    w_we, w_re, w_addr, mac_clr, mac_en, mac_bias, done, category};

  logic signed [7:0] res_tab [7];
  int ridx = 0;
  int rsp_cnt = 0;

  int in_addrs [$];
  int wb_addrs [$];
  int wb_w [$];
  int wb_en [$];
  int wb_bias [$];
  int wcnt = 0;
  int encnt = 0;
  int bias_idx = -1;
  int done_cnt = 0;
  int viol = 0;
  int seqbad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // MAC model: one result per neuron, two cycles after the bias beat
  initial begin
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (!busy) begin
        rsp_cnt = 0;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          res_valid = 1'b1;
          if (ridx < 7) res_data = res_tab[ridx];
          ridx++;
        end
      end
      if (mac_bias) rsp_cnt = 2;
    end
  end

  // Event recorder, sampled mid-cycle after the drivers have settled
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (act_we && !act_wsel) begin
          in_addrs.push_back(int'(act_addr));
          if (!(in_valid && in_ready)) viol++;
        end
        if (w_we) begin
          wcnt++;
          if (!(w_valid && w_ready)) viol++;
        end
        if (mac_en) begin
          if (mac_clr != (encnt == 0)) seqbad++;
          if (mac_bias) bias_idx = encnt;
          encnt++;
        end else if (mac_clr || mac_bias) begin
          seqbad++;
        end
        if (act_we && act_wsel) begin
          wb_addrs.push_back(int'(act_addr));
          wb_w.push_back(wcnt);
          wb_en.push_back(encnt);
          wb_bias.push_back(bias_idx);
          wcnt = 0;
          encnt = 0;
          bias_idx = -1;
        end
        if ($countones({act_we, w_we, act_re, done}) > 1) viol++;
        if (act_re != w_re) viol++;
        if (done) done_cnt++;
      end
    end
  end

  task automatic set_res(input logic signed [7:0] h0, h1, h2, h3, o0, o1, o2);
    res_tab[0] = h0; res_tab[1] = h1; res_tab[2] = h2; res_tab[3] = h3;
    res_tab[4] = o0; res_tab[5] = o1; res_tab[6] = o2;
  endtask

  task automatic clear_log();
    in_addrs.delete(); wb_addrs.delete(); wb_w.delete(); wb_en.delete(); wb_bias.delete();
    wcnt = 0; encnt = 0; bias_idx = -1; done_cnt = 0; ridx = 0;
  endtask

  task automatic run_inf(input bit gaps, input bit poke, output int cyc);
    bit seen;
    clear_log();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    w_valid = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 5);
      if (gaps) begin
        in_valid = ($urandom_range(0, 2) != 0);
        w_valid  = ($urandom_range(0, 2) != 0);
      end
      seen = done;
    end
    check("done_seen", 64'(seen), 64'd1);
    start = 1'b0;
    in_valid = 1'b0;
    w_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(input int exp_cat);
    int obs;
    check("done_count", 64'(done_cnt), 64'd1);
    check("in_writes", 64'(in_addrs.size()), 64'd2);
    for (int r = 0; r < 2; r++) begin
      obs = (r < in_addrs.size()) ? in_addrs[r] : -1;
      check("in_addr", 64'(obs), 64'(r * 4));
    end
    check("wb_writes", 64'(wb_addrs.size()), 64'd7);
    for (int n = 0; n < 7; n++) begin
      obs = (n < wb_addrs.size()) ? wb_addrs[n] : -1;
      check("wb_addr", 64'(obs), 64'(8 + n));
      obs = (n < wb_w.size()) ? wb_w[n] : -1;
      check("w_we_beats", 64'(obs), 64'((n < 4) ? 3 : 2));
      obs = (n < wb_en.size()) ? wb_en[n] : -1;
      check("mac_en_beats", 64'(obs), 64'((n < 4) ? 3 : 2));
      obs = (n < wb_bias.size()) ? wb_bias[n] : -1;
      check("bias_beat", 64'(obs), 64'((n < 4) ? 2 : 1));
    end
    check("handshake_viol", 64'(viol), 64'd0);
    check("mac_seq", 64'(seqbad), 64'd0);
    check("category", 64'(category), 64'(exp_cat));
    check("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    bit hit;

    repeat (2) @(negedge clk);
    check("reset_outs", all_out, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outs", all_out, 64'd0);

    // valids in IDLE must not cause writes
    clear_log();
    in_valid = 1'b1;
    w_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    w_valid = 1'b0;
    @(negedge clk);
    check("idle_in_writes", 64'(in_addrs.size()), 64'd0);
    check("idle_w_writes", 64'(wcnt), 64'd0);

    set_res(8'sd10, -8'sd20, 8'sd30, -8'sd40, 8'sd5, -8'sd3, 8'sd9);
    run_inf(1'b0, 1'b0, cyc);
    check("cycles_zero_wait", 64'(cyc), 64'd67);
    check_run(2);

    set_res(8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd7, 8'sd7, -8'sd1);
    run_inf(1'b1, 1'b1, cyc);
    check_run(0);

    set_res(8'sd2, 8'sd3, 8'sd4, 8'sd5, -8'sd128, -8'sd2, -8'sd5);
    run_inf(1'b1, 1'b0, cyc);
    check_run(1);
    repeat (5) @(negedge clk);
    check("cat_hold_idle", 64'(category), 64'd1);

    // abort during the output-layer MAC
    set_res(8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd9, 8'sd8, 8'sd7);
    clear_log();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    w_valid = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (act_re && wb_addrs.size() >= 4) hit = 1'b1;
    end
    check("reach_l1_mac", 64'(hit), 64'd1);
    check("cat_hold_run", 64'(category), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outs", all_out, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    w_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_idle", all_out, 64'd0);

    set_res(-8'sd1, 8'sd0, 8'sd1, 8'sd2, 8'sd100, 8'sd127, -8'sd128);
    run_inf(1'b0, 1'b0, cyc);
    check("cycles_after_abort", 64'(cyc), 64'd67);
    check_run(1);

    set_res(8'sd0, 8'sd0, 8'sd0, 8'sd0, -8'sd5, -8'sd5, -8'sd4);
    run_inf(1'b1, 1'b0, cyc);
    check_run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
